// File: rtl/spo2_pkg.sv
// Shared types and constants for the SpO2 ratio-of-ratios calculator.
package spo2_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_COLLECT,
    ST_MULT,
    ST_DIV,
    ST_MAP
  } state_e;

  localparam int Q_FRAC     = 8;
  localparam int MAP_OFFSET = 110;
  localparam int MAP_SLOPE  = 25;
  localparam int SPO2_MAX   = 100;
  localparam int R_MAX      = 4095;
  localparam int NUM_W      = 24;
  localparam int DEN_W      = 16;

  // Linear map: SpO2 = 110 - (25*R)>>8, clamped to 0..100.
  function automatic logic [6:0] map_spo2(input logic [11:0] r);
    logic [16:0] prod;
    logic [8:0]  t;
    prod = 17'(MAP_SLOPE) * 17'(r);
    t    = prod[16:Q_FRAC];
    if (t >= 9'(MAP_OFFSET))
      map_spo2 = '0;
    else if ((9'(MAP_OFFSET) - t) > 9'(SPO2_MAX))
      map_spo2 = 7'(SPO2_MAX);
    else
      map_spo2 = 7'(9'(MAP_OFFSET) - t);
  endfunction

endpackage

// File: rtl/seq_divider.sv
// Unsigned restoring divider, one quotient bit per cycle, MSB first.
// The start cycle already performs the first iteration, so done pulses 24 cycles after start.
module seq_divider
  import spo2_pkg::*;
(
  input  logic             CLK,
  input  logic             rst_n,
  input  logic             start,
  input  logic [NUM_W-1:0] dividend,
  input  logic [DEN_W-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [NUM_W-1:0] quotient
);
  localparam int CNT_W = $clog2(NUM_W);

  logic [DEN_W-1:0] rem_q, rem_d, dvs_q, dvs_d;
  logic [NUM_W-1:0] quo_q, quo_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d, done_q, done_d;
  logic [DEN_W-1:0] step_rem, step_dvs;
  logic [NUM_W-1:0] step_quo;
  logic [DEN_W:0]   trial;

  always_comb begin
    step_rem = start ? '0 : rem_q;
    step_quo = start ? dividend : quo_q;
    step_dvs = start ? divisor : dvs_q;
    trial    = {step_rem, step_quo[NUM_W-1]};
    rem_d    = rem_q;
    quo_d    = quo_q;
    dvs_d    = dvs_q;
    cnt_d    = cnt_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    if (start || busy_q) begin
      dvs_d = step_dvs;
      if (trial >= {1'b0, step_dvs}) begin
        rem_d = DEN_W'(trial - {1'b0, step_dvs});
        quo_d = {step_quo[NUM_W-2:0], 1'b1};
      end else begin
        rem_d = trial[DEN_W-1:0];
        quo_d = {step_quo[NUM_W-2:0], 1'b0};
      end
    end
    if (start) begin
      cnt_d  = CNT_W'(NUM_W - 1);
      busy_d = 1'b1;
    end else if (busy_q) begin
      cnt_d = cnt_q - 1'b1;
      if (cnt_q == CNT_W'(1)) begin
        busy_d = 1'b0;
        done_d = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      rem_q  <= '0;
      quo_q  <= '0;
      dvs_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      rem_q  <= rem_d;
      quo_q  <= quo_d;
      dvs_q  <= dvs_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign quotient = quo_q;

endmodule

// File: rtl/spo2_calc.sv
// Per-window RED/IR statistics, ratio-of-ratios R in Q4.8 and linear SpO2 map.
//   state      | meaning
//   ST_IDLE    | controller not settled, accumulators held clear
//   ST_COLLECT | capturing samples, waiting for both channels to fill
//   ST_MULT    | form num/den from snapshot, start divider or flag error
//   ST_DIV     | sequential divide in progress
//   ST_MAP     | saturate R, map to SpO2, pulse valid or error
module spo2_calc
  import spo2_pkg::*;
#(
  parameter int WINDOW = 64,
  parameter int DW     = 8
) (
  input  logic          CLK,
  input  logic          rst_n,
  input  logic          Setting_Done,
  input  logic          LED_RED,
  input  logic          LED_IR,
  input  logic [DW-1:0] RED_ADC_Value,
  input  logic [DW-1:0] IR_ADC_Value,
  output logic [6:0]    SpO2,
  output logic          SpO2_valid,
  output logic [11:0]   R_ratio,
  output logic          Div_err,
  output logic          Overrun
);
  localparam int LOG2W = $clog2(WINDOW);
  localparam int CW    = LOG2W + 1;
  localparam int SW    = DW + LOG2W;

  state_e           state_q, state_d;
  logic             red_led_q, ir_led_q, red_fall_q, red_fall_d, ir_fall_q, ir_fall_d;
  logic [CW-1:0]    cnt_q [2], cnt_d [2];
  logic [DW-1:0]    max_q [2], max_d [2], min_q [2], min_d [2];
  logic [SW-1:0]    sum_q [2], sum_d [2];
  logic [DW-1:0]    ac_q [2], ac_d [2], dc_q [2], dc_d [2];
  logic [DW-1:0]    sample [2];
  logic [1:0]       fall;
  logic             win_close;
  logic             err_q, err_d, valid_q, valid_d, derr_q, derr_d, ovr_q, ovr_d;
  logic [6:0]       spo2_q, spo2_d;
  logic [11:0]      r_q, r_d, r_sat;
  logic [15:0]      prod_num;
  logic [DEN_W-1:0] den;
  logic [NUM_W-1:0] num, div_quo;
  logic             div_start, div_busy, div_done;

  // Channel 0 is RED, channel 1 is IR.
  always_comb begin
    red_fall_d = red_led_q & ~LED_RED;
    ir_fall_d  = ir_led_q & ~LED_IR;
    sample[0]  = RED_ADC_Value;
    sample[1]  = IR_ADC_Value;
    fall       = {ir_fall_q, red_fall_q};
    win_close  = (cnt_q[0] == CW'(WINDOW)) && (cnt_q[1] == CW'(WINDOW));
    ovr_d      = win_close && (state_q != ST_COLLECT);
    for (int ch = 0; ch < 2; ch++) begin
      ac_d[ch]  = ac_q[ch];
      dc_d[ch]  = dc_q[ch];
      cnt_d[ch] = cnt_q[ch];
      max_d[ch] = max_q[ch];
      min_d[ch] = min_q[ch];
      sum_d[ch] = sum_q[ch];
      if (win_close && state_q == ST_COLLECT) begin
        ac_d[ch] = max_q[ch] - min_q[ch];
        dc_d[ch] = sum_q[ch][SW-1:LOG2W];
      end
      if (win_close || !Setting_Done) begin
        cnt_d[ch] = '0;
        max_d[ch] = '0;
        min_d[ch] = '1;
        sum_d[ch] = '0;
      end
      // A capture in the close cycle lands in the freshly cleared window.
      if (Setting_Done && fall[ch] && cnt_d[ch] != CW'(WINDOW)) begin
        cnt_d[ch] = cnt_d[ch] + 1'b1;
        if (sample[ch] > max_d[ch]) max_d[ch] = sample[ch];
        if (sample[ch] < min_d[ch]) min_d[ch] = sample[ch];
        sum_d[ch] = sum_d[ch] + SW'(sample[ch]);
      end
    end
  end

  always_comb begin
    prod_num  = 16'(ac_q[0]) * 16'(dc_q[1]);
    num       = NUM_W'(prod_num) << Q_FRAC;
    den       = DEN_W'(16'(ac_q[1]) * 16'(dc_q[0]));
    r_sat     = (div_quo > NUM_W'(R_MAX)) ? 12'(R_MAX) : div_quo[11:0];
    state_d   = state_q;
    err_d     = err_q;
    div_start = 1'b0;
    spo2_d    = spo2_q;
    r_d       = r_q;
    valid_d   = 1'b0;
    derr_d    = 1'b0;
    case (state_q)
      ST_IDLE:    if (Setting_Done) state_d = ST_COLLECT;
      ST_COLLECT: if (win_close) state_d = ST_MULT;
      ST_MULT: begin
        err_d = (den == '0);
        if (den == '0) begin
          state_d = ST_MAP;
        end else begin
          div_start = 1'b1;
          state_d   = ST_DIV;
        end
      end
      ST_DIV: begin
        if (div_done) state_d = ST_MAP;
        else if (!div_busy) state_d = ST_COLLECT;
      end
      ST_MAP: begin
        state_d = ST_COLLECT;
        if (err_q) begin
          derr_d = 1'b1;
        end else begin
          r_d     = r_sat;
          spo2_d  = map_spo2(r_sat);
          valid_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (!Setting_Done) begin
      state_d   = ST_IDLE;
      div_start = 1'b0;
      spo2_d    = spo2_q;
      r_d       = r_q;
      valid_d   = 1'b0;
      derr_d    = 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      red_led_q  <= 1'b0;
      ir_led_q   <= 1'b0;
      red_fall_q <= 1'b0;
      ir_fall_q  <= 1'b0;
      err_q      <= 1'b0;
      valid_q    <= 1'b0;
      derr_q     <= 1'b0;
      ovr_q      <= 1'b0;
      spo2_q     <= '0;
      r_q        <= '0;
      for (int ch = 0; ch < 2; ch++) begin
        cnt_q[ch] <= '0;
        max_q[ch] <= '0;
        min_q[ch] <= '1;
        sum_q[ch] <= '0;
        ac_q[ch]  <= '0;
        dc_q[ch]  <= '0;
      end
    end else begin
      state_q    <= state_d;
      red_led_q  <= LED_RED;
      ir_led_q   <= LED_IR;
      red_fall_q <= red_fall_d;
      ir_fall_q  <= ir_fall_d;
      err_q      <= err_d;
      valid_q    <= valid_d;
      derr_q     <= derr_d;
      ovr_q      <= ovr_d;
      spo2_q     <= spo2_d;
      r_q        <= r_d;
      cnt_q      <= cnt_d;
      max_q      <= max_d;
      min_q      <= min_d;
      sum_q      <= sum_d;
      ac_q       <= ac_d;
      dc_q       <= dc_d;
    end
  end

  seq_divider u_div (
    .CLK      (CLK),
    .rst_n    (rst_n),
    .start    (div_start),
    .dividend (num),
    .divisor  (den),
    .busy     (div_busy),
    .done     (div_done),
    .quotient (div_quo)
  );

  assign SpO2       = spo2_q;
  assign R_ratio    = r_q;
  assign SpO2_valid = valid_q;
  assign Div_err    = derr_q;
  assign Overrun    = ovr_q;

endmodule
